data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_rr_pick.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data memory arbiter:
//   state_t      - arbiter FSM states (IDLE, ACCESS)
//   port_id_t    - requester identifier (PORT_CPU, PORT_DMA)
//   ADDR_W_DEF   - default word address width
//   DATA_W_DEF   - default data word width
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DMA = 1'b1;

  function automatic port_id_t other_port(input port_id_t id);
    return (id == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick
// Combinational winner selection between the CPU and DMA requesters.
// Ports:
//   cpu_req, dma_req - pending requests
//   ptr              - priority pointer (port favoured when both request)
//   win_id           - selected port, meaningful when valid = 1
//   valid            - at least one request is pending
//   ptr_next         - pointer value to load if this pick is granted
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed CPU-first priority and
// freezes the pointer; otherwise round-robin.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic     cpu_req,
  input  logic     dma_req,
  input  port_id_t ptr,
  output port_id_t win_id,
  output logic     valid,
  output port_id_t ptr_next
);

  always_comb begin
    valid    = cpu_req | dma_req;
    win_id   = PORT_CPU;
    ptr_next = ptr;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    win_id = cpu_req ? PORT_CPU : PORT_DMA;
`else
    if (cpu_req && dma_req) begin
      win_id = ptr;
    end else if (dma_req) begin
      win_id = PORT_DMA;
    end else begin
      win_id = PORT_CPU;
    end
    // After a grant the other port gets first claim on the next contention.
    if (valid) begin
      ptr_next = other_port(win_id);
    end
`endif
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Two-port (CPU, DMA) arbiter in front of a single-port data memory.
// Each access takes one ACCESS cycle followed by one IDLE cycle in which the
// winner's done pulses, giving at most one access every two cycles.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   cpu_/dma_ req, we, addr, wdata    - requester side inputs
//   cpu_/dma_ gnt, done, rdata        - requester side outputs
//   mem_addr, mem_data, mem_we,
//   mem_read, mem_q                   - memory side (write on clk falling
//                                       edge, combinational read)
// Build option: DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_pick).
//
// state  | meaning
// IDLE   | waiting for a request; done of the previous access pulses here
// ACCESS | latched request drives the memory; winner's gnt is high
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_q
);

  state_t            state_q, state_d;
  port_id_t          ptr_q;
  port_id_t          win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_done_q, dma_done_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  port_id_t pick_id;
  logic     pick_valid;
  port_id_t ptr_next;
  logic     capture;

  dmem_rr_pick u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .ptr      (ptr_q),
    .win_id   (pick_id),
    .valid    (pick_valid),
    .ptr_next (ptr_next)
  );

  // Requests are only looked at in IDLE; anything during ACCESS is ignored.
  assign capture = (state_q == IDLE) && pick_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, pointer, done and read-data registers.
  // Reset during ACCESS simply drops the access: done is never set and the
  // rdata registers are cleared rather than loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= PORT_CPU;
      win_q       <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_done_q <= (state_q == ACCESS) && (win_q == PORT_CPU);
      dma_done_q <= (state_q == ACCESS) && (win_q == PORT_DMA);

      if (capture) begin
        win_q <= pick_id;
        ptr_q <= ptr_next;
        if (pick_id == PORT_DMA) begin
          we_q    <= dma_we;
          addr_q  <= dma_addr;
          wdata_q <= dma_wdata;
        end else begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end

      if ((state_q == ACCESS) && !we_q) begin
        if (win_q == PORT_DMA) begin
          dma_rdata_q <= mem_q;
        end else begin
          cpu_rdata_q <= mem_q;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    mem_we   = 1'b0;
    mem_read = 1'b0;
    if (state_q == ACCESS) begin
      cpu_gnt  = (win_q == PORT_CPU);
      dma_gnt  = (win_q == PORT_DMA);
      mem_we   = we_q;
      mem_read = ~we_q;
    end
  end

  // Address and data come straight from the latch so they hold in IDLE.
  assign mem_addr  = addr_q;
  assign mem_data  = wdata_q;
  assign cpu_done  = cpu_done_q;
  assign dma_done  = dma_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_we, mem_read;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_read(mem_read),
    .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on falling edge, combinational read.
  always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_data;
  assign mem_q = mem[mem_addr];

  typedef struct {
    logic          rst;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wd;
    logic          e_cg, e_dg, e_cd, e_dd, e_mwe, e_mrd;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_crd, e_drd;
    logic          chk_md;
    logic [DW-1:0] e_md;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
    input logic ecg, input logic edg, input logic ecd, input logic edd, input logic emwe, input logic emrd,
    input logic [AW-1:0] ema, input logic [DW-1:0] ecrd, input logic [DW-1:0] edrd,
    input logic cmd, input logic [DW-1:0] emd);
    vec_t v;
    v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
    v.e_cg = ecg; v.e_dg = edg; v.e_cd = ecd; v.e_dd = edd; v.e_mwe = emwe; v.e_mrd = emrd;
    v.e_maddr = ema; v.e_crd = ecrd; v.e_drd = edrd; v.chk_md = cmd; v.e_md = emd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
    dma_req = v.d_req; dma_we = v.d_we; dma_addr = v.d_addr; dma_wdata = v.d_wd;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk("cpu_gnt",   idx, DW'(cpu_gnt),   DW'(v.e_cg));
    chk("dma_gnt",   idx, DW'(dma_gnt),   DW'(v.e_dg));
    chk("cpu_done",  idx, DW'(cpu_done),  DW'(v.e_cd));
    chk("dma_done",  idx, DW'(dma_done),  DW'(v.e_dd));
    chk("mem_we",    idx, DW'(mem_we),    DW'(v.e_mwe));
    chk("mem_read",  idx, DW'(mem_read),  DW'(v.e_mrd));
    chk("mem_addr",  idx, DW'(mem_addr),  DW'(v.e_maddr));
    chk("cpu_rdata", idx, cpu_rdata,      v.e_crd);
    chk("dma_rdata", idx, dma_rdata,      v.e_drd);
    if (v.chk_md) chk("mem_data", idx, mem_data, v.e_md);
  endtask

  initial begin
    //             rst cr cw caddr   cwdata        dr dw daddr   dwdata        cg dg cd dd we rd maddr   cpu_rdata     dma_rdata     md mem_data
    vecs[0]  = mk(1, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        32'h0,        1, 32'h0);
    vecs[1]  = mk(0, 1, 1, 9'h010, 32'hDEADBEEF, 0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 1, 0, 9'h010, 32'h0,        32'h0,        1, 32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 1, 0, 0, 0, 9'h010, 32'h0,        32'h0,        1, 32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 0, 9'h000, 32'h0,        1, 0, 9'h010, 32'h0,        0, 1, 0, 0, 0, 1, 9'h010, 32'h0,        32'h0,        0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 0, 0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 32'h0);
    vecs[6]  = mk(0, 1, 1, 9'h020, 32'h12345678, 0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 1, 0, 9'h020, 32'h0,        32'hDEADBEEF, 1, 32'h12345678);
    vecs[7]  = mk(0, 0, 0, 9'h000, 32'h0,        1, 1, 9'h030, 32'h00000BAD, 0, 0, 1, 0, 0, 0, 9'h020, 32'h0,        32'hDEADBEEF, 1, 32'h12345678);
    vecs[8]  = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h020, 32'h0,        32'hDEADBEEF, 1, 32'h12345678);
    vecs[9]  = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h020, 32'h0,        32'hDEADBEEF, 1, 32'h12345678);
    vecs[10] = mk(0, 1, 0, 9'h020, 32'h0,        0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 0, 1, 9'h020, 32'h0,        32'hDEADBEEF, 0, 32'h0);
    vecs[11] = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 1, 0, 0, 0, 9'h020, 32'h12345678, 32'hDEADBEEF, 0, 32'h0);
    vecs[12] = mk(0, 1, 0, 9'h010, 32'h0,        0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 0, 1, 9'h010, 32'h12345678, 32'hDEADBEEF, 0, 32'h0);
    vecs[13] = mk(1, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        32'h0,        1, 32'h0);
    vecs[14] = mk(0, 0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        32'h0,        1, 32'h0);

    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(vecs[i], i);
    end

    // Both requesters held continuously right after reset.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h020; dma_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      logic exp_dma;
      @(posedge clk);
      #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_dma = 1'b0;
`else
      exp_dma = ((i / 2) % 2) == 1;
`endif
      chk("rr_cpu_gnt",  100 + i, DW'(cpu_gnt),  DW'((i % 2 == 0) && !exp_dma));
      chk("rr_dma_gnt",  100 + i, DW'(dma_gnt),  DW'((i % 2 == 0) &&  exp_dma));
      chk("rr_cpu_done", 100 + i, DW'(cpu_done), DW'((i % 2 == 1) && !exp_dma));
      chk("rr_dma_done", 100 + i, DW'(dma_done), DW'((i % 2 == 1) &&  exp_dma));
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    chk("rr_cpu_rdata", 200, cpu_rdata, 32'hDEADBEEF);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("rr_dma_rdata", 200, dma_rdata, 32'h0);
`else
    chk("rr_dma_rdata", 200, dma_rdata, 32'h12345678);
`endif
    @(posedge clk);
    #1;
    chk("rr_idle_gnt", 201, DW'(cpu_gnt | dma_gnt), 32'h0);
    chk("rr_idle_mem", 201, DW'(mem_we | mem_read), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Exclusivity of gnt and done, checked every cycle mid-period.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_gnt && dma_gnt) begin
        errors++;
        $display("FAIL gnt_excl: got both gnt high, expected at most one");
      end
      if (cpu_done && dma_done) begin
        errors++;
        $display("FAIL done_excl: got both done high, expected at most one");
      end
    end
  end

endmodule
